// File: rtl/indep_stim_pkg.sv
// Shared types and constants for the indep stimulus driver and its program store.
package indep_stim_pkg;

  localparam int unsigned CRST_CYCLES  = 2;
  localparam int unsigned MISMATCH_MAX = 255;

  typedef enum logic [2:0] {
    StIdle,
    StCrst,
    StRel,
    StRun,
    StDrain,
    StFin
  } stim_state_e;

  // One program step: stimulus, key bit, expected Mealy word and compare mask.
  typedef struct packed {
    logic [5:0]  x;
    logic        key;
    logic [22:0] exp;
    logic [22:0] mask;
  } stim_step_t;

endpackage

// File: rtl/indep_stim_ram.sv
// Program store: DEPTH x 53-bit simple-dual-port RAM, synchronous write, asynchronous read.
module indep_stim_ram
  import indep_stim_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  stim_step_t    wdata,
  input  logic [AW-1:0] raddr,
  output stim_step_t    rdata
);

  stim_step_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/indep_stim_driver.sv
// Step-program sequencer and masked response checker for the indep controller.
// Define STIM_STOP_ON_FAIL_EN to end a run at its first mismatching step.
module indep_stim_driver
  import indep_stim_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [5:0]    prog_x,
  input  logic          prog_key,
  input  logic [22:0]   prog_exp,
  input  logic [22:0]   prog_mask,
  input  logic [AW:0]   run_len,
  input  logic          start,
  output logic          ctrl_rst,
  output logic [5:0]    x,
  output logic          keyinput0,
  input  logic [22:0]   y,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    mismatch_cnt,
  output logic [AW-1:0] fail_step
);

`ifdef STIM_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  localparam logic [AW:0] LenOne = (AW+1)'(1);

  stim_state_e   state_q, state_d;
  logic [1:0]    crst_cnt_q, crst_cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q;

  stim_step_t    wr_step, rd_step;
  logic          ctrl_rst_q, key_q;
  logic [5:0]    x_q;
  logic          cmp_vld_q;
  logic [22:0]   cmp_exp_q, cmp_mask_q, y_cap_q;
  logic [AW-1:0] cmp_idx_q;
  logic          pass_q;
  logic [7:0]    cnt_q;
  logic [AW-1:0] fail_q;
  logic          mis, last_step, launch;

  assign wr_step = '{x: prog_x, key: prog_key, exp: prog_exp, mask: prog_mask};

  // Read address follows the next index so the step lands on x at the same edge.
  indep_stim_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (prog_we & ~busy),
    .waddr (prog_addr),
    .wdata (wr_step),
    .raddr (idx_d),
    .rdata (rd_step)
  );

  assign mis       = cmp_vld_q & (|((y_cap_q ^ cmp_exp_q) & cmp_mask_q));
  assign last_step = ({1'b0, idx_q} == (len_q - LenOne));
  assign launch    = (state_q == StIdle) & start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      crst_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      crst_cnt_q <= crst_cnt_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    crst_cnt_d = crst_cnt_q;
    idx_d      = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StCrst;
          crst_cnt_d = '0;
        end
      end
      StCrst: begin
        if (crst_cnt_q == 2'(CRST_CYCLES - 1)) begin
          state_d = StRel;
        end else begin
          crst_cnt_d = crst_cnt_q + 2'd1;
        end
      end
      StRel: begin
        idx_d   = '0;
        state_d = (len_q == '0) ? StFin : StRun;
      end
      StRun: begin
        if (last_step || (StopOnFail && mis)) begin
          state_d = StDrain;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StDrain: state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StFin);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_rst_q <= 1'b1;
      x_q        <= '0;
      key_q      <= 1'b0;
      cmp_vld_q  <= 1'b0;
      cmp_exp_q  <= '0;
      cmp_mask_q <= '0;
      cmp_idx_q  <= '0;
    end else begin
      ctrl_rst_q <= (state_d == StCrst);
      cmp_vld_q  <= (state_d == StRun);
      cmp_idx_q  <= idx_d;
      if (state_d == StRun) begin
        x_q        <= rd_step.x;
        key_q      <= rd_step.key;
        cmp_exp_q  <= rd_step.exp;
        cmp_mask_q <= rd_step.mask;
      end else begin
        x_q   <= '0;
        key_q <= 1'b0;
      end
    end
  end

  // The controller advances on the falling edge; sample its Mealy word there.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      y_cap_q <= '0;
    end else begin
      y_cap_q <= y;
    end
  end

  // pass_q still set means no mismatch yet this run, so it also gates fail_step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= 1'b0;
      cnt_q  <= '0;
      fail_q <= '0;
      len_q  <= '0;
    end else if (launch) begin
      pass_q <= 1'b1;
      cnt_q  <= '0;
      fail_q <= '0;
      len_q  <= run_len;
    end else if (mis) begin
      pass_q <= 1'b0;
      if (cnt_q != 8'(MISMATCH_MAX)) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (pass_q) begin
        fail_q <= cmp_idx_q;
      end
    end
  end

  assign ctrl_rst     = ctrl_rst_q;
  assign x            = x_q;
  assign keyinput0    = key_q;
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign fail_step    = fail_q;

endmodule

// File: tb/tb_indep_stim_driver.sv
// Directed bench for indep_stim_driver with a behavioural stand-in controller and run scoreboard.
module tb_indep_stim_driver;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam logic [5:0]  LOOP  = 6'b000110;

  typedef struct {
    bit pass;
    int cnt;
    int fs;
  } res_t;

  logic          clk, rst;
  logic          prog_we, prog_key, start;
  logic [AW-1:0] prog_addr;
  logic [5:0]    prog_x;
  logic [22:0]   prog_exp, prog_mask;
  logic [AW:0]   run_len;
  logic          ctrl_rst, keyinput0, busy, done, pass;
  logic [5:0]    x;
  logic [22:0]   y;
  logic [7:0]    mismatch_cnt;
  logic [AW-1:0] fail_step;

  logic [5:0]  m_x    [DEPTH];
  logic        m_key  [DEPTH];
  logic [22:0] m_exp  [DEPTH];
  logic [22:0] m_mask [DEPTH];
  res_t        sb [$];
  int          npass = 0;
  int          ntot  = 0;
  int          lp_cnt;
  logic        troj;

  indep_stim_driver #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_x       (prog_x),
    .prog_key     (prog_key),
    .prog_exp     (prog_exp),
    .prog_mask    (prog_mask),
    .run_len      (run_len),
    .start        (start),
    .ctrl_rst     (ctrl_rst),
    .x            (x),
    .keyinput0    (keyinput0),
    .y            (y),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .mismatch_cnt (mismatch_cnt),
    .fail_step    (fail_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in controller: Mealy word is a fixed function of the inputs, except that
  // from the 5th keyed visit of LOOP on, y23 is suppressed.
  function automatic logic [22:0] ctl_f(input logic [5:0] xv, input logic kv);
    return {xv[1:0], kv, xv, kv, xv, kv, xv};
  endfunction

  always @(negedge clk) begin
    if (ctrl_rst) lp_cnt <= 0;
    else if (keyinput0 && x == LOOP) lp_cnt <= lp_cnt + 1;
  end

  assign troj = keyinput0 && (x == LOOP) && (lp_cnt >= 4);
  assign y    = ctl_f(x, keyinput0) ^ (troj ? 23'h400000 : 23'h0);

  function automatic res_t model_run(input int len);
    res_t r;
    int lp;
    logic [22:0] yv;
    r.pass = 1'b1; r.cnt = 0; r.fs = 0; lp = 0;
    for (int i = 0; i < len; i++) begin
      yv = ctl_f(m_x[i], m_key[i]);
      if (m_key[i] && m_x[i] == LOOP) begin
        if (lp >= 4) yv[22] = ~yv[22];
        lp++;
      end
      if (((yv ^ m_exp[i]) & m_mask[i]) != 23'h0) begin
        if (r.pass) r.fs = i;
        r.pass = 1'b0;
        if (r.cnt < 255) r.cnt++;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
  endtask

  task automatic wr(input int a, input logic [5:0] xv, input logic kv,
                    input logic [22:0] ev, input logic [22:0] mv);
    prog_addr = a[AW-1:0]; prog_x = xv; prog_key = kv; prog_exp = ev; prog_mask = mv;
    prog_we = 1'b1;
    m_x[a] = xv; m_key[a] = kv; m_exp[a] = ev; m_mask[a] = mv;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // Called just after a posedge; returns just after a posedge.
  task automatic do_run(input string tag, input int len, input bit poke);
    res_t r, e;
    int lat, k;
    bit seen;
    logic [7:0] exp_o;
    e = model_run(len);
    sb.push_back(e);
    lat = (len == 0) ? 4 : 5 + len;
    run_len = len[AW:0];
    start = 1'b1;
    seen = 1'b0;
    k = 1;
    while (!seen && k <= lat + 3) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (poke && k == 2) start = 1'b1;
      if (poke && k == 3) begin
        start = 1'b0;
        prog_addr = '0; prog_x = 6'h3f; prog_key = 1'b1; prog_exp = '0; prog_mask = '1;
        prog_we = 1'b1;
      end
      if (poke && k == 4) prog_we = 1'b0;
      exp_o = {(k <= lat) ? 1'b1 : 1'b0, (k == 1 || k == 2) ? 1'b1 : 1'b0, 6'h0};
      if (k >= 4 && k < 4 + len) exp_o[5:0] = {m_x[k-4][4:0], m_key[k-4]};
      chk({tag, "_cyc"}, {busy, ctrl_rst, x, keyinput0},
          {exp_o[7:6], (k >= 4 && k < 4 + len) ? m_x[k-4] : 6'h0,
           (k >= 4 && k < 4 + len) ? m_key[k-4] : 1'b0});
      if (done) begin
        seen = 1'b1;
        chk({tag, "_lat"}, k, lat);
        r = sb.pop_front();
        chk({tag, "_pass"}, pass, r.pass);
        chk({tag, "_cnt"}, mismatch_cnt, r.cnt);
        chk({tag, "_fs"}, fail_step, r.fs);
      end
      k++;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 0, 1);
      void'(sb.pop_front());
    end
    @(posedge clk); #1;
    chk({tag, "_after"}, {busy, done}, 2'b00);
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_x = '0; prog_key = 1'b0;
    prog_exp = '0; prog_mask = '0; run_len = '0; start = 1'b0;

    // Reset handshake
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vals", {ctrl_rst, x, keyinput0, busy, done, pass, mismatch_cnt, fail_step},
        {1'b1, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0});
    rst = 1'b0;
    #1;
    chk("rst_crst_hold", ctrl_rst, 1'b1);
    @(posedge clk); #1;
    chk("rst_crst_drop", ctrl_rst, 1'b0);

    // Golden path
    wr(0, 6'b001100, 1'b0, ctl_f(6'b001100, 1'b0), '1);
    wr(1, 6'b001101, 1'b0, ctl_f(6'b001101, 1'b0), '1);
    wr(2, 6'b101100, 1'b0, ctl_f(6'b101100, 1'b0), '1);
    wr(3, 6'b011100, 1'b0, ctl_f(6'b011100, 1'b0), '1);
    do_run("golden", 4, 1'b0);
    chk("golden_pass", pass, 1'b1);

    // Forced mismatch at step 2; step 4 differs only in a masked-off bit
    wr(2, 6'b000100, 1'b0, ctl_f(6'b000100, 1'b0) ^ 23'h010000, '1);
    wr(4, 6'b110011, 1'b0, ctl_f(6'b110011, 1'b0) ^ 23'h000020, ~23'h000020);
    do_run("mism", 5, 1'b0);
    chk("mism_fs", fail_step, 8'd2);
    chk("mism_cnt", mismatch_cnt, 8'd1);

    // Zero-length run: pass must be re-armed by start
    do_run("len0", 0, 1'b0);
    chk("len0_pass", pass, 1'b1);

    // start and prog_we during busy are ignored; then confirm RAM unchanged
    do_run("poke", 5, 1'b1);
    do_run("poke_ram", 5, 1'b0);

    // Trojan detect: key=1 program visiting LOOP every third step
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 2) wr(i, LOOP, 1'b1, ctl_f(LOOP, 1'b1), 23'h400000);
      else            wr(i, 6'b101001, 1'b1, ctl_f(6'b101001, 1'b1), '1);
    end
    do_run("troj", 40, 1'b0);
    chk("troj_fs", fail_step, 8'd14);
    chk("troj_cnt", mismatch_cnt, 8'd9);

    // Reset asserted while step 3 is driven
    run_len = 9'd40;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_step3_x", {x, keyinput0}, {6'b101001, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_vals", {ctrl_rst, x, keyinput0, busy, done, pass, mismatch_cnt, fail_step},
        {1'b1, 6'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0});
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_idle", {busy, ctrl_rst}, 2'b00);
    do_run("troj_again", 40, 1'b0);

    // Saturation: every step mismatches
    for (int i = 0; i < 256; i++) begin
      wr(i, i[5:0], 1'b0, ~ctl_f(i[5:0], 1'b0), '1);
    end
    do_run("sat256", 256, 1'b0);
    chk("sat_cnt", mismatch_cnt, 8'd255);
    do_run("sat44", 44, 1'b0);
    chk("sat44_cnt", mismatch_cnt, 8'd44);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
